// File: rtl/wb_port_arbiter_if.sv
// Writeback request bus between the N writeback sources and the register-file write port.
// The slave side is the arbiter; the master side is the requesters plus the register file.
interface wb_port_arbiter_if #(
  parameter int N     = 3,
  parameter int CNT_W = 32
) ();
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_reg;
  logic [N*64-1:0] req_data;
  logic            wb_hold;
  logic            regWrite;
  logic [4:0]      writeReg;
  logic [63:0]     writeData_R;
  logic            bypass_valid;
  logic [CNT_W-1:0] contention_cnt;

  modport slave (
    input  req_valid, req_reg, req_data, wb_hold,
    output req_ready, regWrite, writeReg, writeData_R, bypass_valid, contention_cnt
  );

  modport master (
    output req_valid, req_reg, req_data, wb_hold,
    input  req_ready, regWrite, writeReg, writeData_R, bypass_valid, contention_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among N writeback sources.
// The winning write is registered (latency 1) and doubles as a bypass source.
module wb_port_arbiter #(
  parameter int N     = 3,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   wb
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic int unsigned popcount(input logic [N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  logic [4:0]  reg_a  [N];
  logic [63:0] data_a [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign reg_a[gi]  = wb.req_reg[gi*5 +: 5];
    assign data_a[gi] = wb.req_data[gi*64 +: 64];
  end

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             regWrite_q, regWrite_d;
  logic [4:0]       writeReg_q, writeReg_d;
  logic [63:0]      writeData_q, writeData_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     grant;
  logic             hs;
  logic [PTR_W-1:0] win;

  // Grant: first valid requester scanning ptr, ptr+1, ... with wraparound
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    grant = '0;
    hs    = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    if (!reset && !wb.wb_hold) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx -= N;
        cand = PTR_W'(idx);
        if (!hs && wb.req_valid[cand]) begin
          hs          = 1'b1;
          win         = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    cnt_d       = cnt_q;
    if (hs) begin
      ptr_d       = (int'(win) == N - 1) ? '0 : win + PTR_W'(1);
      writeReg_d  = reg_a[win];
      writeData_d = data_a[win];
      // x0 writes consume the slot but never reach the register file
      regWrite_d  = (reg_a[win] != 5'd0);
    end
    if (!reset && !wb.wb_hold && popcount(wb.req_valid) >= 2)
      cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb.req_ready      = grant;
  assign wb.regWrite       = regWrite_q;
  assign wb.bypass_valid   = regWrite_q;
  assign wb.writeReg       = writeReg_q;
  assign wb.writeData_R    = writeData_q;
  assign wb.contention_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_wb_port_arbiter;
  localparam int N       = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.N(N), .CNT_W(CNT_W)) bus ();

  wb_port_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference state
  int          m_ptr = 0;
  bit          m_rw  = 0;
  logic [4:0]  m_wr  = '0;
  logic [63:0] m_wd  = '0;
  int          m_cnt = 0;
  int          last_g = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_grant();
    if (reset || bus.wb_hold) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [4:0] r, input logic [63:0] d);
    bus.req_reg[i*5 +: 5]   = r;
    bus.req_data[i*64 +: 64] = d;
  endtask

  // One clock cycle: inputs are already driven just after the falling edge.
  task automatic cycle();
    int g;
    #1;
    g = ref_grant();
    last_g = g;
    chk("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("regWrite", 64'(bus.regWrite), 64'(m_rw));
    chk("bypass_valid", 64'(bus.bypass_valid), 64'(m_rw));
    chk("writeReg", 64'(bus.writeReg), 64'(m_wr));
    chk("writeData_R", bus.writeData_R, m_wd);
    chk("contention_cnt", 64'(bus.contention_cnt), 64'(m_cnt));
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_rw = 0; m_wr = '0; m_wd = '0; m_cnt = 0;
    end else begin
      if (!bus.wb_hold && $countones(bus.req_valid) >= 2 && m_cnt < CNT_MAX) m_cnt++;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        m_wr  = bus.req_reg[g*5 +: 5];
        m_wd  = bus.req_data[g*64 +: 64];
        m_rw  = (m_wr != 5'd0);
      end else begin
        m_rw = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] c0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;
    bus.wb_hold   = 1'b0;
    @(negedge clk);

    // reset then idle
    cycle(); cycle();
    reset = 1'b0;
    repeat (3) cycle();
    chk("idle_cnt", 64'(bus.contention_cnt), 64'd0);
    chk("idle_rw", 64'(bus.regWrite), 64'd0);

    // single requester
    bus.req_valid = 3'b001;
    set_req(0, 5'd5, 64'hDEAD_BEEF);
    cycle();
    chk("single_rw", 64'(bus.regWrite), 64'd1);
    chk("single_wreg", 64'(bus.writeReg), 64'd5);
    chk("single_wdata", bus.writeData_R, 64'hDEAD_BEEF);
    bus.req_valid = '0;
    cycle();
    chk("single_drop_rw", 64'(bus.regWrite), 64'd0);

    // round-robin fairness from reset
    reset = 1'b1; cycle(); reset = 1'b0;
    set_req(0, 5'd1, 64'h100); set_req(1, 5'd2, 64'h200); set_req(2, 5'd3, 64'h300);
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_wreg", 64'(bus.writeReg), 64'((k % 3) + 1));
      chk("rr_rw", 64'(bus.regWrite), 64'd1);
    end
    chk("rr_cnt", 64'(bus.contention_cnt), 64'd6);
    bus.req_valid = '0;

    // x0 write advances the pointer without writing
    reset = 1'b1; cycle(); reset = 1'b0;
    bus.req_valid = 3'b001; set_req(0, 5'd9, 64'h9);
    cycle();
    bus.req_valid = 3'b010; set_req(1, 5'd0, 64'h1234);
    cycle();
    chk("x0_rw", 64'(bus.regWrite), 64'd0);
    bus.req_valid = 3'b101; set_req(0, 5'd10, 64'hA); set_req(2, 5'd11, 64'hB);
    cycle();
    chk("x0_next_wreg", 64'(bus.writeReg), 64'd11);
    chk("x0_next_rw", 64'(bus.regWrite), 64'd1);

    // hold freezes grant, pointer and counter
    set_req(0, 5'd1, 64'h100); set_req(1, 5'd2, 64'h200); set_req(2, 5'd3, 64'h300);
    bus.req_valid = 3'b111; bus.wb_hold = 1'b1;
    c0 = 32'(bus.contention_cnt);
    cycle(); cycle();
    chk("hold_cnt", 64'(bus.contention_cnt), 64'(c0));
    chk("hold_rw", 64'(bus.regWrite), 64'd0);
    bus.wb_hold = 1'b0;
    cycle();
    chk("hold_release_wreg", 64'(bus.writeReg), 64'd1);

    // reset mid-stream discards the pending write
    bus.req_valid = 3'b010; set_req(1, 5'd7, 64'h77);
    cycle();
    chk("pre_rst_wreg", 64'(bus.writeReg), 64'd7);
    reset = 1'b1; bus.req_valid = '0;
    cycle();
    chk("rst_rw", 64'(bus.regWrite), 64'd0);
    reset = 1'b0; bus.req_valid = 3'b111; set_req(1, 5'd2, 64'h200);
    cycle();
    chk("rst_first_wreg", 64'(bus.writeReg), 64'd1);

    // counter saturation
    reset = 1'b1; cycle(); reset = 1'b0;
    repeat (20) cycle();
    chk("sat_cnt", 64'(bus.contention_cnt), 64'(CNT_MAX));
    bus.req_valid = '0;
    cycle();

    // randomized traffic; pending requests keep reg/data until granted or dropped
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(63) == 0);
      bus.wb_hold = ($urandom_range(7) == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && last_g != i) begin
          if ($urandom_range(7) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          bus.req_valid[i] = 1'b1;
          set_req(i, ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31)),
                  {32'($urandom), 32'($urandom)});
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
